// File: rtl/fir_mac_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_mac_seq_pkg                                              |
// | Description : Shared state encoding and default widths for the polyphase   |
// |               FIR MAC sequencer and its DSP slice.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fir_mac_seq_pkg;

  // Default widths, shared with the DSP MAC slice instantiated by the parent.
  localparam int c_N_TAPS       = 8;
  localparam int c_A_DATA_WIDTH = 25;
  localparam int c_B_DATA_WIDTH = 18;
  localparam int c_P_DATA_WIDTH = 48;

  // Sequencer states; encodings are fixed so the DSP side can decode them too.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // True when a coefficient index addresses a real tap. Only differs from
  // "always true" when N_TAPS is not a power of two.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned n_taps);
    return addr < n_taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_coef_ram                                                 |
// | Description : N_TAPS x B_DATA_WIDTH coefficient register file, async       |
// |               reset, synchronous write, combinational read.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_coef_ram
  import fir_mac_seq_pkg::*;
#(
  parameter int N_TAPS       = c_N_TAPS,
  parameter int B_DATA_WIDTH = c_B_DATA_WIDTH,
  parameter int ADDR_WIDTH   = $clog2(N_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic        [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic signed [B_DATA_WIDTH-1:0] wr_data_i,
  input  logic        [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic signed [B_DATA_WIDTH-1:0] rd_data_o
);

  logic signed [B_DATA_WIDTH-1:0] mem_q [N_TAPS];
  logic                           wr_en_w;

  // Out-of-range indices are silently dropped rather than aliased.
  assign wr_en_w = we_i && addr_in_range(32'(wr_addr_i), N_TAPS);

  // Coefficient storage; reset clears every tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_w) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_mac_seq                                                  |
// | Description : MAC sequencer for one polyphase FIR branch. Shifts samples   |
// |               into an N_TAPS window, steps w[k]*coef[k] through an         |
// |               external single-DSP MAC slice and strobes out the sum.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_mac_seq
  import fir_mac_seq_pkg::*;
#(
  parameter int N_TAPS       = c_N_TAPS,
  parameter int A_DATA_WIDTH = c_A_DATA_WIDTH,
  parameter int B_DATA_WIDTH = c_B_DATA_WIDTH,
  parameter int P_DATA_WIDTH = c_P_DATA_WIDTH,
  localparam int ADDR_WIDTH  = $clog2(N_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coef_we,
  input  logic        [ADDR_WIDTH-1:0]   coef_addr,
  input  logic signed [B_DATA_WIDTH-1:0] coef_di,
  input  logic signed [A_DATA_WIDTH-1:0] din,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic                           dsp_acc,
  output logic signed [A_DATA_WIDTH-1:0] dsp_a,
  output logic signed [B_DATA_WIDTH-1:0] dsp_b,
  input  logic signed [P_DATA_WIDTH-1:0] dsp_p,
  output logic signed [P_DATA_WIDTH-1:0] dout,
  output logic                           dout_valid
);

  localparam logic [ADDR_WIDTH-1:0] c_K_LAST = ADDR_WIDTH'(N_TAPS - 1);

  state_t                         state_q, state_d;
  logic        [ADDR_WIDTH-1:0]   k_q, k_d;
  logic signed [A_DATA_WIDTH-1:0] win_q [N_TAPS];
  logic signed [P_DATA_WIDTH-1:0] dout_q;
  logic                           dout_valid_q;
  logic signed [B_DATA_WIDTH-1:0] coef_rd_w;
  logic                           accept_w;

  // Coefficients may only change while no MAC pass is using them.
  fir_coef_ram #(
    .N_TAPS       (N_TAPS),
    .B_DATA_WIDTH (B_DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_coef_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (coef_we && (state_q == IDLE)),
    .wr_addr_i (coef_addr),
    .wr_data_i (coef_di),
    .rd_addr_i (k_q),
    .rd_data_o (coef_rd_w)
  );

  // State and tap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic and DSP operand steering.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept_w = 1'b0;
    dsp_a    = '0;
    dsp_b    = '0;
    dsp_acc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          accept_w = 1'b1;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        dsp_a   = win_q[k_q];
        dsp_b   = coef_rd_w;
        // First tap loads the product, the rest accumulate onto it.
        dsp_acc = (k_q != '0);
        if (k_q == c_K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // The DSP's registered output now holds the full sum.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sample window: newest sample enters at w[0], oldest falls off the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept_w) begin
      win_q[0] <= din;
      for (int i = 1; i < N_TAPS; i++) begin
        win_q[i] <= win_q[i-1];
      end
    end
  end

  // Result capture: dout holds between results, valid pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= (state_q == DRAIN);
      if (state_q == DRAIN) begin
        dout_q <= dsp_p;
      end
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_mac_seq                                               |
// | Description : Self-checking bench for fir_mac_seq (N_TAPS=4) wired to a    |
// |               behavioural DSP MAC slice, plus a small N_TAPS=5 instance.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_mac_seq;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int BW = 18;
  localparam int PW = 48;

  localparam logic signed [AW-1:0] SP = 25'sd8388607;  // +0x7FFFFF
  localparam logic signed [AW-1:0] SM = 25'sh1000000;  // most negative sample

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 coef_we = 1'b0;
  logic [1:0]           coef_addr = '0;
  logic signed [BW-1:0] coef_di = '0;
  logic signed [AW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 din_ready, dsp_acc, dout_valid;
  logic signed [AW-1:0] dsp_a;
  logic signed [BW-1:0] dsp_b;
  logic signed [PW-1:0] dsp_p = '0;
  logic signed [PW-1:0] dout;
  logic signed [PW-1:0] prod;

  always #5 clk = ~clk;

  fir_mac_seq #(.N_TAPS(N), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .P_DATA_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_di(coef_di),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .dsp_acc(dsp_acc),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_p(dsp_p), .dout(dout), .dout_valid(dout_valid)
  );

  // DSP MAC slice model: registered product/accumulate, one-cycle latency.
  assign prod = dsp_a * dsp_b;
  always @(posedge clk) begin
    if (rst) dsp_p <= '0;
    else     dsp_p <= dsp_acc ? dsp_p + prod : prod;
  end

  // Second instance with a non-power-of-two tap count for out-of-range writes.
  logic                 c5_we = 1'b0;
  logic [2:0]           c5_addr = '0;
  logic signed [BW-1:0] c5_di = '0;
  logic signed [AW-1:0] din5 = '0;
  logic                 v5 = 1'b0;
  logic                 rdy5, acc5, dout_valid5;
  logic signed [AW-1:0] a5;
  logic signed [BW-1:0] b5;
  logic signed [PW-1:0] p5 = '0;
  logic signed [PW-1:0] dout5;
  logic signed [PW-1:0] prod5;

  fir_mac_seq #(.N_TAPS(5), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .P_DATA_WIDTH(PW)) dut5 (
    .clk(clk), .rst(rst), .coef_we(c5_we), .coef_addr(c5_addr), .coef_di(c5_di),
    .din(din5), .din_valid(v5), .din_ready(rdy5), .dsp_acc(acc5),
    .dsp_a(a5), .dsp_b(b5), .dsp_p(p5), .dout(dout5), .dout_valid(dout_valid5)
  );

  assign prod5 = a5 * b5;
  always @(posedge clk) begin
    if (rst) p5 <= '0;
    else     p5 <= acc5 ? p5 + prod5 : prod5;
  end

  // Bookkeeping and scoreboard.
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     last_acc = -1;
  bit     prev_v = 1'b0;
  longint exp_q[$];
  int     acc_q[$];

  typedef struct {
    logic signed [AW-1:0] din;
    longint               exp;
  } vec_t;
  vec_t tbl [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard and checks value, latency and pulse width.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout_valid", longint'(dout), -1);
        end else begin
          longint e;
          int     a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("dout_value", longint'(dout), e);
          chk("dout_latency", longint'(cyc - a), 5);
        end
        chk("dout_valid_pulse_width", longint'(prev_v), 0);
      end
      prev_v = dout_valid;
    end
  end

  task automatic wr_coef(input logic [1:0] a, input logic signed [BW-1:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_di = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Offer one sample; hold keeps din_valid asserted afterwards for back-to-back.
  task automatic send(input logic signed [AW-1:0] s, input longint e, input bit hold);
    int n;
    @(negedge clk);
    din = s; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      chk("send_ready_timeout", 0, 1);
      din_valid = 1'b0;
      last_acc = -1;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    if (last_acc >= 0) chk("accept_spacing", longint'(cyc + 1 - last_acc), 6);
    last_acc = hold ? cyc + 1 : -1;
    @(posedge clk); #1;
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !din_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int vcnt;
    int n;

    // Impulse response with coefs {1,2,3,4}, then coefs all -1 with full-scale
    // positive and most-negative samples, then a flush of zeros.
    tbl[0]  = '{25'sd1, 64'sd1};
    tbl[1]  = '{25'sd0, 64'sd2};
    tbl[2]  = '{25'sd0, 64'sd3};
    tbl[3]  = '{25'sd0, 64'sd4};
    tbl[4]  = '{SP, -64'sd8388607};
    tbl[5]  = '{SP, -64'sd16777214};
    tbl[6]  = '{SP, -64'sd25165821};
    tbl[7]  = '{SP, -64'sd33554428};
    tbl[8]  = '{SM, -64'sd8388605};
    tbl[9]  = '{SM, 64'sd16777218};
    tbl[10] = '{SM, 64'sd41943041};
    tbl[11] = '{SM, 64'sd67108864};
    tbl[12] = '{25'sd0, 64'sd50331648};
    tbl[13] = '{25'sd0, 64'sd33554432};
    tbl[14] = '{25'sd0, 64'sd16777216};
    tbl[15] = '{25'sd0, 64'sd0};

    // Reset values.
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_din_ready", longint'(din_ready), 1);
    chk("reset_dsp_a", longint'(dsp_a), 0);
    chk("reset_dsp_b", longint'(dsp_b), 0);
    chk("reset_dsp_acc", longint'(dsp_acc), 0);
    chk("reset_dout", longint'(dout), 0);
    chk("reset_dout_valid", longint'(dout_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table run: din_valid held high inside each group of four.
    for (int j = 0; j < N; j++) wr_coef(2'(j), 18'(j + 1));
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        wait_idle();
        for (int j = 0; j < N; j++) wr_coef(2'(j), -18'sd1);
      end
      send(tbl[i].din, tbl[i].exp, (i != 3) && (i != 15));
    end
    wait_idle();

    // Coefficient write during MAC is dropped.
    for (int j = 0; j < N; j++) wr_coef(2'(j), 18'(j + 1));
    send(25'sd1, 1, 1'b0);
    @(negedge clk);
    chk("ready_low_in_mac", longint'(din_ready), 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_di = 18'sd100;
    @(posedge clk); #1;
    coef_we = 1'b0;
    send(25'sd0, 2, 1'b0);
    send(25'sd0, 3, 1'b0);
    send(25'sd0, 4, 1'b0);
    wait_idle();

    // Same write in IDLE takes effect.
    wr_coef(2'd0, 18'sd100);
    send(25'sd1, 100, 1'b0);
    send(25'sd0, 2, 1'b0);
    send(25'sd0, 3, 1'b0);
    send(25'sd0, 4, 1'b0);
    send(25'sd0, 0, 1'b0);
    wait_idle();

    // Coefficient write and sample accept in the same IDLE cycle.
    @(negedge clk);
    chk("ready_before_simul", longint'(din_ready), 1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_di = 18'sd5;
    din = 25'sd1; din_valid = 1'b1;
    exp_q.push_back(5);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    coef_we = 1'b0; din_valid = 1'b0;
    wait_idle();

    // Reset mid-MAC: window is {7,1,0,0}, coefs {5,2,3,4}.
    @(negedge clk);
    din = 25'sd7; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    chk("k1_dsp_a", longint'(dsp_a), 1);
    chk("k1_dsp_b", longint'(dsp_b), 2);
    chk("k1_dsp_acc", longint'(dsp_acc), 1);
    @(posedge clk); #1;
    chk("k2_dsp_b", longint'(dsp_b), 3);
    chk("k2_dsp_acc", longint'(dsp_acc), 1);
    rst = 1'b1;
    #1;
    chk("midrst_din_ready", longint'(din_ready), 1);
    chk("midrst_dsp_a", longint'(dsp_a), 0);
    chk("midrst_dsp_b", longint'(dsp_b), 0);
    chk("midrst_dsp_acc", longint'(dsp_acc), 0);
    chk("midrst_dout", longint'(dout), 0);
    chk("midrst_dout_valid", longint'(dout_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (dout_valid) vcnt++;
    end
    chk("midrst_no_dout_valid", longint'(vcnt), 0);
    // Stale window {1,7,1,0} or stale coefs would give a nonzero sum here.
    wr_coef(2'd2, 18'sd1);
    send(25'sd1, 0, 1'b0);
    wait_idle();

    // N_TAPS=5: write to index 7 is out of range and must not disturb tap 0.
    @(negedge clk);
    c5_we = 1'b1; c5_addr = 3'd0; c5_di = 18'sd6;
    @(posedge clk); #1;
    c5_addr = 3'd7; c5_di = 18'sd99;
    @(posedge clk); #1;
    c5_we = 1'b0;
    @(negedge clk);
    din5 = 25'sd2; v5 = 1'b1;
    @(posedge clk); #1;
    v5 = 1'b0;
    n = 0;
    while (!dout_valid5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("n5_dout_valid_seen", longint'(dout_valid5), 1);
    chk("n5_dout", longint'(dout5), 12);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
